// File: rtl/seg7_num_display_if.sv
// rtl/seg7_num_display_if.sv - load/result bundle between the result register and the HEX display driver.
interface seg7_num_display_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
);
  logic                  load;
  logic [WIDTH-1:0]      value;
  logic                  signed_mode;
  logic                  lz_blank;
  logic [0:7*DIGITS-1]   hex;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    output load, value, signed_mode, lz_blank,
    input  hex, busy, done, overflow
  );

  modport slave (
    input  load, value, signed_mode, lz_blank,
    output hex, busy, done, overflow
  );
endinterface

// File: rtl/seg7_num_display.sv
// rtl/seg7_num_display.sv - binary to multi-digit seven-segment driver using an iterative double-dabble engine.
module seg7_num_display #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_num_display_if.slave  bus
);

  function automatic int calc_nbcd(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n = n + 1;
    end
    return n;
  endfunction

  localparam int NBCD = calc_nbcd(WIDTH);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

  // Bit 0 of each code is segment a; all codes are active-low.
  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0011000;
      default: seg_code = SEG_OFF;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [4*NBCD-1:0]     bcd_q, bcd_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic                  lzb_q, lzb_d;
  logic [0:7*DIGITS-1]   hex_q, hex_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic [4*NBCD-1:0]     bcd_adj;
  logic [0:7*DIGITS-1]   hex_fmt;
  logic                  ovf_fmt;
  logic [3:0]            nib;
  logic [6:0]            seg;
  int                    msn;

  // Add-3 correction applied before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Final formatting from the completed BCD accumulator; a negative value reserves the top digit for minus.
  always_comb begin
    ovf_fmt = 1'b0;
    msn     = 0;
    nib     = 4'd0;
    seg     = SEG_OFF;
    hex_fmt = '1;
    for (int i = 0; i < NBCD; i++) begin
      nib = bcd_q[4*i +: 4];
      if (nib != 4'd0) begin
        msn = i;
        if (neg_q ? (i >= DIGITS - 1) : (i >= DIGITS)) ovf_fmt = 1'b1;
      end
    end
    for (int d = 0; d < DIGITS; d++) begin
      nib = 4'(bcd_q >> (4 * d));
      if (ovf_fmt) begin
        seg = SEG_MINUS;
      end else if (lzb_q && d > msn) begin
        seg = (neg_q && d == msn + 1) ? SEG_MINUS : SEG_OFF;
      end else if (!lzb_q && neg_q && d == DIGITS - 1) begin
        seg = SEG_MINUS;
      end else begin
        seg = seg_code(nib);
      end
      for (int k = 0; k < 7; k++) hex_fmt[7*d + k] = seg[k];
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    lzb_d   = lzb_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          neg_d   = bus.signed_mode & bus.value[WIDTH-1];
          mag_d   = neg_d ? (~bus.value + ONE) : bus.value;
          lzb_d   = bus.lz_blank;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FORMAT;
      end
      FORMAT: begin
        hex_d   = hex_fmt;
        ovf_d   = ovf_fmt;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      lzb_q   <= 1'b0;
      hex_q   <= '1;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      lzb_q   <= lzb_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.hex      = hex_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seg7_num_display.sv
// tb/tb_seg7_num_display.sv - scoreboard bench for seg7_num_display (DIGITS=4, WIDTH=14).
module tb_seg7_num_display;
  localparam int D = 4;
  localparam int W = 14;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] OFF   = 7'b1111111;

  typedef struct {
    logic [0:7*D-1] hex;
    logic           ovf;
    int             start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  exp_t sbq[$];

  seg7_num_display_if #(.DIGITS(D), .WIDTH(W)) bus ();

  seg7_num_display #(.DIGITS(D), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] digit_code(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0011000;
    endcase
  endfunction

  function automatic exp_t model(input int v, input bit sm, input bit lz);
    exp_t e;
    int vv, mag, t, m;
    bit neg, ovf;
    int dg[8];
    logic [6:0] s;
    vv  = v & 16383;
    neg = sm && (((vv >> 13) & 1) == 1);
    mag = neg ? 16384 - vv : vv;
    t = mag;
    for (int i = 0; i < 8; i++) begin
      dg[i] = t % 10;
      t = t / 10;
    end
    ovf = neg ? (mag >= 1000) : (mag >= 10000);
    m = 0;
    for (int i = 0; i < 8; i++) if (dg[i] != 0) m = i;
    for (int d = 0; d < D; d++) begin
      if (ovf) s = MINUS;
      else if (lz && d > m) s = (neg && d == m + 1) ? MINUS : OFF;
      else if (!lz && neg && d == D - 1) s = MINUS;
      else s = digit_code(dg[d]);
      for (int k = 0; k < 7; k++) e.hex[7*d + k] = s[k];
    end
    e.ovf = ovf;
    e.start = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hex", bus.hex, e.hex);
        chk("overflow", bus.overflow, e.ovf);
        chk("latency", cyc - e.start, W + 1);
      end
    end
  end

  task automatic wait_done(input int n0);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > n0) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic drive(input int v, input bit sm, input bit lz);
    bus.value       = v[W-1:0];
    bus.signed_mode = sm;
    bus.lz_blank    = lz;
    bus.load        = 1'b1;
  endtask

  task automatic run_conv(input int v, input bit sm, input bit lz);
    exp_t e;
    int n0;
    @(negedge clk);
    drive(v, sm, lz);
    e = model(v, sm, lz);
    e.start = cyc + 1;
    sbq.push_back(e);
    n0 = done_cnt;
    @(posedge clk);
    #1 bus.load = 1'b0;
    chk("busy_after_load", bus.busy, 1);
    wait_done(n0);
    chk("busy_after_done", bus.busy, 0);
  endtask

  initial begin
    exp_t e;
    int n0;
    bus.load = 1'b0;
    bus.value = '0;
    bus.signed_mode = 1'b0;
    bus.lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hex", bus.hex, 28'hFFFFFFF);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.overflow, 0);
    @(negedge clk) rst_n = 1'b1;

    // Conversion aborted by asynchronous reset mid-shift.
    run_conv(10000, 0, 0);
    @(negedge clk);
    drive(1234, 0, 0);
    @(posedge clk);
    #1 bus.load = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hex", bus.hex, 28'hFFFFFFF);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_ovf", bus.overflow, 0);
    @(negedge clk) rst_n = 1'b1;

    run_conv(1234, 0, 0);
    run_conv(-7, 1, 1);
    run_conv(0, 0, 1);
    run_conv(10000, 0, 0);
    run_conv(-1000, 1, 0);
    run_conv(-999, 1, 0);
    run_conv(-999, 1, 1);
    run_conv(-8192, 1, 1);
    run_conv(16383, 0, 0);
    run_conv(9999, 0, 0);
    run_conv(0, 0, 0);
    run_conv(-5, 1, 0);
    run_conv(42, 0, 1);
    run_conv(8192, 0, 1);

    // Loads at E5 and E15 ignored; load at E16 accepted.
    @(negedge clk);
    drive(1111, 0, 0);
    e = model(1111, 0, 0);
    e.start = cyc + 1;
    sbq.push_back(e);
    n0 = done_cnt;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 5 || k == W + 1) drive(2222, 0, 1);
      else bus.load = 1'b0;
    end
    @(negedge clk);
    drive(3333, 0, 0);
    e = model(3333, 0, 0);
    e.start = cyc + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1 bus.load = 1'b0;
    wait_done(n0 + 1);
    repeat (3) @(negedge clk);
    chk("handshake_done_count", done_cnt - n0, 2);

    for (int r = 0; r < 8; r++) begin
      run_conv(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
